actv_layer_bridge: RTL
======================

Name: actv_layer_bridge

Overview:
- Downstream responder for a RAM-based NN layer; sits between two layers.
- Owns the activation-output buffer that the producing layer writes through its out-activation RAM port.
- Answers the producing layer's req/ack handshake. On a request it copies every buffered activation into the next layer's input-activation RAM port.
- Then hands off with a req/ack handshake toward the next layer.

Parameters:
- NumOutputs, 15, neurons in the producing layer; also the buffer depth.
- DataWidth, 8, activation word width in fixed point.
- AddrWidth, $clog2(NumOutputs), buffer and downstream address width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous reset, active-low.
- wr_addr_i  in  AddrWidth  producing-layer buffer address.
- wr_we_i  in  1  producing-layer write enable.
- wr_data_i  in  DataWidth  producing-layer write data.
- rd_data_o  out  DataWidth  read data for wr_addr_i; 1-cycle latency.
- up_req_i  in  1  producing layer signals "outputs complete" (its req_o).
- up_ack_o  out  1  acknowledge to producing layer (its ack_i).
- dn_addr_o  out  AddrWidth  next-layer input RAM address.
- dn_we_o  out  1  next-layer input RAM write enable.
- dn_data_o  out  DataWidth  next-layer input RAM write data.
- dn_req_o  out  1  request to next layer (its req_i).
- dn_ack_i  in  1  acknowledge from next layer.
- err_o  out  1  sticky error: a write was dropped.

Behaviour:
- Reset (reset_i=0 at a clk_i edge):
  - State goes to IDLE.
  - All outputs become 0, including rd_data_o.
  - Counters and err_o clear.
  - Buffer contents are not cleared.
  - Reset mid-COPY or mid-HANDOFF aborts immediately; no further dn_we_o pulses.
- Buffer is 2-port, registered read:
  - Port A: layer write/read.
  - Port B: copy read.
- Port A writes:
  - Accepted only in IDLE with wr_addr_i < NumOutputs.
  - A write with wr_addr_i >= NumOutputs is dropped and sets err_o.
  - A write in any state other than IDLE is dropped and sets err_o.
  - rd_data_o = mem[wr_addr_i] sampled one cycle earlier, in all states.
  - Read-during-write to the same address returns the old data.
- FSM states: IDLE, COPY, HANDOFF, WAIT_DROP.
- IDLE:
  - Leaves for COPY when up_req_i=1 is sampled at edge T.
  - The copy counter loads 0.
- COPY:
  - Port B reads address cnt each cycle; cnt increments through 0..NumOutputs-1.
  - The registered write stage produces dn_we_o=1, dn_addr_o=k, dn_data_o=mem[k] at edge T+2+k, for k=0..NumOutputs-1.
  - This is exactly NumOutputs consecutive pulses, in ascending address order.
  - dn_addr_o and dn_data_o hold their last values when dn_we_o=0.
  - After the last read is issued, the next state is HANDOFF.
- HANDOFF:
  - Entry: up_ack_o and dn_req_o both rise together at edge T+NumOutputs+2; dn_we_o is 0 on that same edge.
  - up_ack_o holds until up_req_i=0 is sampled, then drops the next edge.
  - dn_req_o holds until dn_ack_i=1 is sampled, then drops the next edge.
  - The two sides are independent; both may drop on the same edge.
  - Leaves for WAIT_DROP once both have dropped.
- WAIT_DROP:
  - Waits for dn_ack_i=0, then goes to IDLE (4-phase completion).
  - If up_req_i is already high again on IDLE entry, the next transfer starts on the following edge.
- up_req_i falling during COPY is ignored; the copy completes.
- dn_ack_i=1 on HANDOFF entry: dn_req_o still asserts for one cycle, then drops.
- Throughput: back-to-back transfers are separated by at least NumOutputs+5 cycles.
- Width rules: data passes unmodified; the address counter stops at NumOutputs-1 and never wraps.

Test Plan:
- Reset values: hold reset_i=0 for 3 cycles with random inputs -> every output 0; err_o=0.
- Basic transfer (N=15, DW=8):
  - Stimulus: write mem[k]=8'h10+k for k=0..14, then pulse up_req_i high at T.
  - Required: dn_we_o high edges T+2..T+16; dn_addr_o 0..14; dn_data_o 8'h10..8'h1E.
  - Required: up_ack_o and dn_req_o rise at T+17.
- Handshake ordering:
  - Stimulus: drop up_req_i 3 cycles after up_ack_o; raise dn_ack_i 7 cycles after dn_req_o; drop dn_ack_i 2 cycles later.
  - Required: up_ack_o falls 1 edge after up_req_i falls; dn_req_o falls 1 edge after dn_ack_i rises; IDLE 1 edge after dn_ack_i falls.
- Dropped writes:
  - Stimulus: write addr 15 in IDLE; write addr 3 during COPY.
  - Required: mem unchanged (readback via rd_data_o); err_o=1 and sticky until reset.
- Reset mid-copy: assert reset_i=0 at copy cycle k=5 -> dn_we_o=0 next edge and stays 0; state IDLE; a new up_req_i starts a fresh copy from address 0.
- Readback: write 8'hA5 at addr 7, then read addr 7 -> rd_data_o=8'hA5 one cycle later. Same-cycle read/write of a new value returns the old value.

Source files
------------

// File: rtl/actv_layer_bridge_if.sv
// Bundle of the producing-layer port, upstream handshake and next-layer write port.
// The bridge uses the slave view; the surrounding layers (or a bench) use master.
interface actv_layer_bridge_if #(
  parameter int NumOutputs = 15,
  parameter int DataWidth  = 8,
  parameter int AddrWidth  = $clog2(NumOutputs)
);
  logic [AddrWidth-1:0] wr_addr_i;
  logic                 wr_we_i;
  logic [DataWidth-1:0] wr_data_i;
  logic [DataWidth-1:0] rd_data_o;
  logic                 up_req_i;
  logic                 up_ack_o;
  logic [AddrWidth-1:0] dn_addr_o;
  logic                 dn_we_o;
  logic [DataWidth-1:0] dn_data_o;
  logic                 dn_req_o;
  logic                 dn_ack_i;
  logic                 err_o;

  modport slave (
    input  wr_addr_i, wr_we_i, wr_data_i, up_req_i, dn_ack_i,
    output rd_data_o, up_ack_o, dn_addr_o, dn_we_o, dn_data_o, dn_req_o, err_o
  );

  modport master (
    output wr_addr_i, wr_we_i, wr_data_i, up_req_i, dn_ack_i,
    input  rd_data_o, up_ack_o, dn_addr_o, dn_we_o, dn_data_o, dn_req_o, err_o
  );
endinterface

// File: rtl/actv_layer_bridge.sv
// Activation buffer between two RAM-based layers: collects one layer's outputs,
// streams them into the next layer's input RAM, then runs both req/ack handshakes.
module actv_layer_bridge #(
  parameter int NumOutputs = 15,
  parameter int DataWidth  = 8,
  parameter int AddrWidth  = $clog2(NumOutputs)
) (
  input  logic clk_i,
  input  logic reset_i,
  actv_layer_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COPY, HANDOFF, WAIT_DROP} state_t;

  localparam int                   Depth    = 1 << AddrWidth;
  localparam logic [AddrWidth:0]   Count    = (AddrWidth + 1)'(NumOutputs);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumOutputs - 1);

  // Padded to a power of two so out-of-range port A reads stay inside the array;
  // the extra entries are never written.
  logic [DataWidth-1:0] mem [Depth];

  state_t               state_reg;
  logic [AddrWidth-1:0] cnt_reg;
  logic                 rd_valid_reg;
  logic [AddrWidth-1:0] rd_addr_reg;
  logic [DataWidth-1:0] rd_a_reg;
  logic [DataWidth-1:0] rd_b_reg;
  logic                 dn_we_reg;
  logic [AddrWidth-1:0] dn_addr_reg;
  logic [DataWidth-1:0] dn_data_reg;
  logic                 up_ack_reg;
  logic                 dn_req_reg;
  logic                 armed_reg;
  logic                 err_reg;
  logic                 wr_ok;

  assign wr_ok = reset_i && bus.wr_we_i && (state_reg == IDLE)
                 && ({1'b0, bus.wr_addr_i} < Count);

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[bus.wr_addr_i] <= bus.wr_data_i;
    end
    if (state_reg == COPY) begin
      rd_b_reg <= mem[cnt_reg];
    end
  end

  // Port A read register: old data on a same-address write.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rd_a_reg <= '0;
    end else begin
      rd_a_reg <= mem[bus.wr_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      dn_we_reg    <= 1'b0;
      dn_addr_reg  <= '0;
      dn_data_reg  <= '0;
      up_ack_reg   <= 1'b0;
      dn_req_reg   <= 1'b0;
      armed_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      dn_we_reg    <= rd_valid_reg;
      rd_valid_reg <= 1'b0;
      if (rd_valid_reg) begin
        dn_addr_reg <= rd_addr_reg;
        dn_data_reg <= rd_b_reg;
      end
      if (bus.wr_we_i && !wr_ok) begin
        err_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (bus.up_req_i) begin
            state_reg <= COPY;
            cnt_reg   <= '0;
          end
        end
        COPY: begin
          rd_valid_reg <= 1'b1;
          rd_addr_reg  <= cnt_reg;
          if (cnt_reg == LastAddr) begin
            state_reg <= HANDOFF;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HANDOFF: begin
          // Raise both handshakes only once the final write has left the pipeline.
          if (!armed_reg) begin
            if (dn_we_reg && (dn_addr_reg == LastAddr)) begin
              up_ack_reg <= 1'b1;
              dn_req_reg <= 1'b1;
              armed_reg  <= 1'b1;
            end
          end else begin
            if (up_ack_reg && !bus.up_req_i) begin
              up_ack_reg <= 1'b0;
            end
            if (dn_req_reg && bus.dn_ack_i) begin
              dn_req_reg <= 1'b0;
            end
            if (!up_ack_reg && !dn_req_reg) begin
              armed_reg <= 1'b0;
              state_reg <= WAIT_DROP;
            end
          end
        end
        WAIT_DROP: begin
          if (!bus.dn_ack_i) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rd_data_o = rd_a_reg;
  assign bus.up_ack_o  = up_ack_reg;
  assign bus.dn_addr_o = dn_addr_reg;
  assign bus.dn_we_o   = dn_we_reg;
  assign bus.dn_data_o = dn_data_reg;
  assign bus.dn_req_o  = dn_req_reg;
  assign bus.err_o     = err_reg;
endmodule
